kanagawa_dcram_read_stage: RTL and testbench

//  Read-side controller for a dual-clock FIFO built on KanagawaHALDualClockDualPortRAM.

---
 rtl/kanagawa_dcram_read_stage.sv | 90 +++++++++
 tb/tb_kanagawa_dcram_read_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kanagawa_dcram_read_stage.sv
// Read-side controller for a dual-clock FIFO on a fixed-latency dual-port RAM.
// Issues RAM reads against credit, captures returning words, streams them out.
module kanagawa_dcram_read_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic                  rdclk,
  input  logic                  rdrst_n,
  input  logic [ADDR_WIDTH:0]   wrptr_sync_in,
  output logic [ADDR_WIDTH:0]   rdptr_out,
  output logic [ADDR_WIDTH-1:0] readaddr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_out
);

  localparam int OBUF_DEPTH = READ_LATENCY + 2;
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + 1) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OBUF_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(OBUF_DEPTH - 1);

  logic [ADDR_WIDTH:0]     rdptr_q, rdptr_d, avail;
  logic [READ_LATENCY-1:0] infl_q, infl_d;
  logic [CW-1:0]           icnt_q, icnt_d;
  logic [CW-1:0]           ocnt_q, ocnt_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [DATA_WIDTH-1:0]   obuf_q [OBUF_DEPTH];
  logic                    issue, cap, pop;

  assign avail = wrptr_sync_in - rdptr_q;
  // Credit counts only registered state; a same-cycle pop frees nothing yet.
  assign issue = (avail != '0) && ((icnt_q + ocnt_q) < DEPTH_C);
  assign cap   = infl_q[READ_LATENCY-1];
  assign pop   = valid_out && ready_in;

  always_comb begin
    rdptr_d = rdptr_q + (ADDR_WIDTH+1)'(issue);
    infl_d = '0;
    infl_d[0] = issue;
    for (int i = 1; i < READ_LATENCY; i++) begin
      infl_d[i] = infl_q[i-1];
    end
    icnt_d = icnt_q + CW'(issue) - CW'(cap);
    ocnt_d = ocnt_q + CW'(cap) - CW'(pop);
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = (head_q == LAST_C) ? '0 : head_q + 1'b1;
    end
    if (cap) begin
      tail_d = (tail_q == LAST_C) ? '0 : tail_q + 1'b1;
    end
  end

  always_ff @(posedge rdclk or negedge rdrst_n) begin
    if (!rdrst_n) begin
      rdptr_q <= '0;
      infl_q  <= '0;
      icnt_q  <= '0;
      ocnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf_q[i] <= '0;
      end
    end else begin
      rdptr_q <= rdptr_d;
      infl_q  <= infl_d;
      icnt_q  <= icnt_d;
      ocnt_q  <= ocnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (cap) begin
        obuf_q[tail_q] <= ram_data_in;
      end
    end
  end

  assign rdptr_out    = rdptr_q;
  assign readaddr_out = rdptr_q[ADDR_WIDTH-1:0];
  assign valid_out    = (ocnt_q != '0);
  assign data_out     = obuf_q[head_q];
  assign empty_out    = (ocnt_q == '0) && (icnt_q == '0) && (avail == '0);

endmodule

// File: tb/tb_kanagawa_dcram_read_stage.sv
// Bench for kanagawa_dcram_read_stage: 2-cycle RAM model, write-side model,
// and a scoreboard popped by an independent output monitor.
module tb_kanagawa_dcram_read_stage;

  logic        clk;
  logic        rdrst_n;
  logic [9:0]  wrptr_sync_in;
  logic [9:0]  rdptr_out;
  logic [8:0]  readaddr_out;
  logic [31:0] ram_data_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] data_out;
  logic        empty_out;

  kanagawa_dcram_read_stage #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .READ_LATENCY(2)
  ) dut (
    .rdclk(clk),
    .rdrst_n(rdrst_n),
    .wrptr_sync_in(wrptr_sync_in),
    .rdptr_out(rdptr_out),
    .readaddr_out(readaddr_out),
    .ram_data_in(ram_data_in),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .data_out(data_out),
    .empty_out(empty_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [8:0]  ra_q;
  always @(posedge clk) begin
    ra_q        <= readaddr_out;
    ram_data_in <= mem[ra_q];
  end

  int          n_chk;
  int          n_fail;
  logic [31:0] sb [$];
  logic [9:0]  wp;
  int          seq;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdrst_n && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", {32'h0, data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("sb_data", {32'h0, data_out}, {32'h0, sb.pop_front()});
      end
    end
  end

  logic       saw_addr_wrap, saw_ptr_wrap;
  logic [8:0] prev_addr;
  logic [9:0] prev_ptr;
  always @(negedge clk) begin
    if (prev_addr == 9'd511 && readaddr_out == 9'd0) saw_addr_wrap = 1'b1;
    if (prev_ptr == 10'd1023 && rdptr_out == 10'd0) saw_ptr_wrap = 1'b1;
    prev_addr = readaddr_out;
    prev_ptr  = rdptr_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] v);
    mem[wp[8:0]] = v;
    sb.push_back(v);
    wp = wp + 10'd1;
    wrptr_sync_in = wp;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push_one(32'hD000_0000 + 32'(seq));
      seq++;
    end
  endtask

  task automatic drain(input string nm, input int maxc);
    int c;
    c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
    step();
    step();
  endtask

  task automatic do_reset();
    rdrst_n = 1'b0;
    wrptr_sync_in = '0;
    wp = '0;
    sb.delete();
    repeat (3) step();
    rdrst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] first;
    int          run;
    n_chk = 0;
    n_fail = 0;
    seq = 0;
    wp = '0;
    saw_addr_wrap = 1'b0;
    saw_ptr_wrap = 1'b0;
    prev_addr = '0;
    prev_ptr = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    rdrst_n = 1'b0;
    ready_in = 1'b1;
    wrptr_sync_in = '0;

    // reset state
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_rdptr", 64'(rdptr_out), 64'd0);
    step();
    rdrst_n = 1'b1;

    // idle 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", 64'(valid_out), 64'd0);
      chk("idle_empty", 64'(empty_out), 64'd1);
      chk("idle_rdptr", 64'(rdptr_out), 64'd0);
      step();
    end

    // single word latency: avail in cycle N, valid in N+3
    push_one(32'h0000_A5A5);
    @(negedge clk);
    chk("lat_addr_n", 64'(readaddr_out), 64'd0);
    chk("lat_empty_n", 64'(empty_out), 64'd0);
    chk("lat_valid_n", 64'(valid_out), 64'd0);
    @(negedge clk);
    chk("lat_rdptr_n1", 64'(rdptr_out), 64'd1);
    chk("lat_valid_n1", 64'(valid_out), 64'd0);
    @(negedge clk);
    chk("lat_valid_n2", 64'(valid_out), 64'd0);
    @(negedge clk);
    chk("lat_valid_n3", 64'(valid_out), 64'd1);
    chk("lat_data_n3", 64'(data_out), 64'h0000_A5A5);
    @(negedge clk);
    chk("lat_valid_n4", 64'(valid_out), 64'd0);
    chk("lat_empty_n4", 64'(empty_out), 64'd1);
    step();

    // 64-word burst, no bubbles
    push_n(64);
    run = 0;
    while (!valid_out && run < 20) begin
      @(negedge clk);
      run++;
    end
    chk("burst_start", 64'(valid_out), 64'd1);
    run = 0;
    for (int i = 0; i < 63; i++) begin
      @(negedge clk);
      if (valid_out) run++;
    end
    chk("burst_no_bubble", 64'(run), 64'd63);
    @(negedge clk);
    chk("burst_end_valid", 64'(valid_out), 64'd0);
    chk("burst_sb_empty", 64'(sb.size()), 64'd0);
    step();

    // backpressure: credit limits issue to 4
    do_reset();
    ready_in = 1'b0;
    first = 32'hD000_0000 + 32'(seq);
    push_n(16);
    repeat (10) step();
    @(negedge clk);
    chk("bp_rdptr", 64'(rdptr_out), 64'd4);
    chk("bp_valid", 64'(valid_out), 64'd1);
    chk("bp_data", 64'(data_out), 64'(first));
    repeat (3) step();
    @(negedge clk);
    chk("bp_data_stable", 64'(data_out), 64'(first));
    chk("bp_rdptr_held", 64'(rdptr_out), 64'd4);
    step();
    ready_in = 1'b1;
    drain("bp_drain", 60);
    chk("bp_final_rdptr", 64'(rdptr_out), 64'd16);

    // run 1020 words then cross the pointer wrap
    do_reset();
    for (int k = 0; k < 17; k++) begin
      push_n(60);
      drain("wrap_pre_drain", 120);
    end
    chk("wrap_pre_rdptr", 64'(rdptr_out), 64'd1020);
    saw_addr_wrap = 1'b0;
    saw_ptr_wrap = 1'b0;
    push_n(10);
    drain("wrap_drain", 40);
    chk("wrap_addr_seen", 64'(saw_addr_wrap), 64'd1);
    chk("wrap_ptr_seen", 64'(saw_ptr_wrap), 64'd1);
    chk("wrap_rdptr", 64'(rdptr_out), 64'd6);
    chk("wrap_addr", 64'(readaddr_out), 64'd6);

    // reset mid-burst
    do_reset();
    push_n(8);
    run = 0;
    while (!valid_out && run < 20) begin
      @(negedge clk);
      run++;
    end
    chk("mid_started", 64'(valid_out), 64'd1);
    step();
    rdrst_n = 1'b0;
    wrptr_sync_in = '0;
    wp = '0;
    sb.delete();
    #1;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_empty", 64'(empty_out), 64'd1);
    chk("mid_rst_rdptr", 64'(rdptr_out), 64'd0);
    repeat (3) step();
    rdrst_n = 1'b1;
    run = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_out) run++;
    end
    chk("mid_no_stale", 64'(run), 64'd0);
    step();
    push_n(3);
    drain("mid_recover", 30);
    chk("mid_recover_rdptr", 64'(rdptr_out), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
